// File: rtl/instr_feeder.sv
// instr_feeder: small program buffer that replays a loaded instruction sequence
// to a datapath over a valid/ready handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load_en/addr/data   write port into the program buffer (IDLE/DONE only)
//   prog_len            number of words to run, sampled on start, clamped to DEPTH
//   start               begin a run from index 0
//   instr_ready         datapath accepts the presented word
//   instr_valid         instruction/pc are valid
//   instruction, pc     current word and its byte address (index*4)
//   busy, done          run in progress / run finished
//   inst_count          accepted words in the current or last run
//
// Optional build macro: INSTR_FEEDER_END_MARKER_EN -- a zero word reached in
// ISSUE terminates the run early without being presented.
module instr_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   inst_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   inst_count_q, inst_count_d;
    logic [31:0]       gap_cnt_q, gap_cnt_d;

    logic [DATA_W-1:0] prog_mem_q [DEPTH];

    logic              addr_ok;
    logic              wr_en;
    logic [DATA_W-1:0] cur_word;
    logic [ADDR_W:0]   len_clamped;
    logic              last;
    logic              end_marker;

    // When the buffer fills the whole index space every address is legal.
    if (DEPTH >= (1 << ADDR_W)) begin : g_full
        assign addr_ok = 1'b1;
    end else begin : g_part
        assign addr_ok = (load_addr < ADDR_W'(DEPTH));
    end

    assign wr_en       = load_en && addr_ok &&
                         (state_q == ST_IDLE || state_q == ST_DONE);
    assign cur_word    = prog_mem_q[index_q];
    assign len_clamped = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;
    assign last        = (({1'b0, index_q} + (ADDR_W+1)'(1)) == len_q);
    assign inst_count  = inst_count_q;

`ifdef INSTR_FEEDER_END_MARKER_EN
    assign end_marker = (cur_word == '0);
`else
    assign end_marker = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        len_d        = len_q;
        inst_count_d = inst_count_q;
        gap_cnt_d    = gap_cnt_q;
        instr_valid  = 1'b0;
        instruction  = '0;
        pc           = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    index_d      = '0;
                    inst_count_d = '0;
                    gap_cnt_d    = '0;
                    len_d        = len_clamped;
                    state_d      = (len_clamped == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (end_marker) begin
                    state_d = ST_DONE;
                end else begin
                    instr_valid = 1'b1;
                    instruction = cur_word;
                    pc          = 32'({index_q, 2'b00});
                    if (instr_ready) begin
                        inst_count_d = inst_count_q + 1'b1;
                        if (last) begin
                            state_d = ST_DONE;
                        end else if (GAP == 0) begin
                            index_d = index_q + 1'b1;
                        end else begin
                            // index advances on leaving GAP so pc stays coherent
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if ((gap_cnt_q + 32'd1) == 32'(GAP)) begin
                    state_d = ST_ISSUE;
                    index_d = index_q + 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            len_q        <= '0;
            inst_count_q <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            len_q        <= len_d;
            inst_count_q <= inst_count_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Buffer is deliberately outside reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            prog_mem_q[load_addr] <= load_data;
        end
    end

endmodule
